// File: rtl/rx_link_pkg.sv
// Shared constants, state encoding and parity helper for the serial RX link controller.
package rx_link_pkg;

    localparam logic [7:0] SYNC_WORD  = 8'hD5;
    localparam logic [1:0] LOCK_CNT   = 2'd3;
    localparam logic [2:0] UNLOCK_CNT = 3'd4;
    localparam logic [4:0] STUCK_BITS = 5'd24;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } linkState_t;

    // Even parity bit: makes the total count of ones over payload+parity even.
    function automatic logic evenParity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/bit_run_monitor.sv
// Counts consecutive equal bits on the recovered line and flags a stuck line.
module bit_run_monitor
    import rx_link_pkg::*;
(
    input  logic i_clk,
    input  logic i_res_n,
    input  logic i_Clear,
    input  logic i_Bit,
    input  logic i_BitEn,
    output logic o_Stuck,
    output logic o_StuckHit
);

    logic [4:0] runCnt_r;
    logic [4:0] runNext_s;
    logic       lastBit_r;
    logic       stuck_r;

    // Next run length: restart on a transition, otherwise count up to saturation.
    always_comb begin
        runNext_s = runCnt_r;
        if (i_Bit != lastBit_r) begin
            runNext_s = 5'd1;
        end else if (runCnt_r == STUCK_BITS) begin
            runNext_s = STUCK_BITS;
        end else begin
            runNext_s = runCnt_r + 5'd1;
        end
    end

    // Single-cycle indication on the bit that first reaches saturation.
    assign o_StuckHit = i_BitEn & ~i_Clear & (runNext_s == STUCK_BITS) & (runCnt_r != STUCK_BITS);
    assign o_Stuck    = stuck_r;

    // Run length and stuck flag registers.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            runCnt_r  <= 5'd0;
            lastBit_r <= 1'b0;
            stuck_r   <= 1'b0;
        end else if (i_Clear) begin
            runCnt_r  <= 5'd0;
            lastBit_r <= 1'b0;
            stuck_r   <= 1'b0;
        end else if (i_BitEn) begin
            runCnt_r  <= runNext_s;
            lastBit_r <= i_Bit;
            stuck_r   <= (runNext_s == STUCK_BITS);
        end
    end

endmodule

// File: rtl/rx_link_ctrl.sv
// Serial RX link controller: sync hunt, lock/unlock hysteresis, payload delivery and error counting.
module rx_link_ctrl
    import rx_link_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_RecoveryData,
    input  logic       i_DataEn,
    input  logic       i_Enable,
    input  logic       i_ErrClr,
    output logic [7:0] o_RxData,
    output logic       o_RxValid,
    output logic       o_LinkUp,
    output logic       o_FrameErr,
    output logic       o_Stuck,
    output logic [7:0] o_ErrCnt
);

    linkState_t state_r;
    logic [7:0] shift_r;
    logic [7:0] payload_r;
    logic [7:0] rxData_r;
    logic [7:0] errCnt_r;
    logic [4:0] bitPos_r;
    logic [1:0] goodCnt_r;
    logic [2:0] badCnt_r;
    logic       syncOk_r;
    logic       rxValid_r;
    logic       frameErr_r;
    logic       linkUp_r;

    logic       bitEn_s;
    logic       stuckHit_s;
    logic [7:0] shiftNext_s;
    logic       syncBit_s;
    logic       frameGood_s;
    logic       errInc_s;

    assign bitEn_s     = i_DataEn & i_Enable;
    assign shiftNext_s = {shift_r[6:0], i_RecoveryData};
    assign syncBit_s   = SYNC_WORD[3'd7 - bitPos_r[2:0]];
    assign frameGood_s = syncOk_r & (i_RecoveryData == evenParity(payload_r));
    assign errInc_s    = bitEn_s & ~stuckHit_s & (state_r == LOCKED)
                       & (bitPos_r == 5'd16) & ~frameGood_s;

    bit_run_monitor u_runMon (
        .i_clk      (i_clk),
        .i_res_n    (i_res_n),
        .i_Clear    (~i_Enable),
        .i_Bit      (i_RecoveryData),
        .i_BitEn    (bitEn_s),
        .o_Stuck    (o_Stuck),
        .o_StuckHit (stuckHit_s)
    );

    // Link state machine with frame tracking and registered strobes.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state_r    <= HUNT;
            shift_r    <= 8'h00;
            payload_r  <= 8'h00;
            rxData_r   <= 8'h00;
            bitPos_r   <= 5'd0;
            goodCnt_r  <= 2'd0;
            badCnt_r   <= 3'd0;
            syncOk_r   <= 1'b0;
            rxValid_r  <= 1'b0;
            frameErr_r <= 1'b0;
            linkUp_r   <= 1'b0;
        end else begin
            rxValid_r  <= 1'b0;
            frameErr_r <= 1'b0;
            if (!i_Enable) begin
                state_r   <= HUNT;
                shift_r   <= 8'h00;
                bitPos_r  <= 5'd0;
                goodCnt_r <= 2'd0;
                badCnt_r  <= 3'd0;
                syncOk_r  <= 1'b0;
                linkUp_r  <= 1'b0;
            end else if (i_DataEn) begin
                if (stuckHit_s) begin
                    state_r   <= HUNT;
                    shift_r   <= shiftNext_s;
                    bitPos_r  <= 5'd0;
                    goodCnt_r <= 2'd0;
                    badCnt_r  <= 3'd0;
                    linkUp_r  <= 1'b0;
                end else begin
                    case (state_r)
                        HUNT: begin
                            shift_r <= shiftNext_s;
                            if (shiftNext_s == SYNC_WORD) begin
                                bitPos_r  <= 5'd8;
                                goodCnt_r <= 2'd0;
                                syncOk_r  <= 1'b1;
                                state_r   <= VERIFY;
                            end
                        end
                        VERIFY, LOCKED: begin
                            if (bitPos_r < 5'd8) begin
                                syncOk_r <= ((bitPos_r == 5'd0) | syncOk_r) & (i_RecoveryData == syncBit_s);
                            end else if (bitPos_r < 5'd16) begin
                                payload_r <= {payload_r[6:0], i_RecoveryData};
                            end
                            if (bitPos_r == 5'd16) begin
                                bitPos_r <= 5'd0;
                                if (state_r == VERIFY) begin
                                    if (!frameGood_s) begin
                                        state_r   <= HUNT;
                                        shift_r   <= 8'h00;
                                        goodCnt_r <= 2'd0;
                                    end else if (goodCnt_r + 2'd1 == LOCK_CNT) begin
                                        state_r   <= LOCKED;
                                        linkUp_r  <= 1'b1;
                                        goodCnt_r <= 2'd0;
                                        badCnt_r  <= 3'd0;
                                    end else begin
                                        goodCnt_r <= goodCnt_r + 2'd1;
                                    end
                                end else if (frameGood_s) begin
                                    rxData_r  <= payload_r;
                                    rxValid_r <= 1'b1;
                                    badCnt_r  <= 3'd0;
                                end else begin
                                    frameErr_r <= 1'b1;
                                    // Frame boundary is kept even on a bad sync; unlock only after a run of bad frames.
                                    if (badCnt_r + 3'd1 == UNLOCK_CNT) begin
                                        state_r  <= HUNT;
                                        shift_r  <= 8'h00;
                                        badCnt_r <= 3'd0;
                                        linkUp_r <= 1'b0;
                                    end else begin
                                        badCnt_r <= badCnt_r + 3'd1;
                                    end
                                end
                            end else begin
                                bitPos_r <= bitPos_r + 5'd1;
                            end
                        end
                        default: begin
                            state_r  <= HUNT;
                            linkUp_r <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Saturating bad-frame counter; a clear wins over a coincident increment.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            errCnt_r <= 8'h00;
        end else if (i_ErrClr) begin
            errCnt_r <= 8'h00;
        end else if (errInc_s && (errCnt_r != 8'hFF)) begin
            errCnt_r <= errCnt_r + 8'h01;
        end
    end

    assign o_RxData   = rxData_r;
    assign o_RxValid  = rxValid_r;
    assign o_LinkUp   = linkUp_r;
    assign o_FrameErr = frameErr_r;
    assign o_ErrCnt   = errCnt_r;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Directed self-checking bench for rx_link_ctrl: lock, errors, unlock, stuck line, saturation, enable, reset.
module tb_rx_link_ctrl;

    logic       i_clk = 1'b0;
    logic       i_res_n = 1'b0;
    logic       i_RecoveryData = 1'b0;
    logic       i_DataEn = 1'b0;
    logic       i_Enable = 1'b1;
    logic       i_ErrClr = 1'b0;
    logic [7:0] o_RxData;
    logic       o_RxValid;
    logic       o_LinkUp;
    logic       o_FrameErr;
    logic       o_Stuck;
    logic [7:0] o_ErrCnt;

    int checks = 0;
    int errors = 0;
    int validCnt = 0;
    int ferrCnt = 0;

    rx_link_ctrl dut (
        .i_clk          (i_clk),
        .i_res_n        (i_res_n),
        .i_RecoveryData (i_RecoveryData),
        .i_DataEn       (i_DataEn),
        .i_Enable       (i_Enable),
        .i_ErrClr       (i_ErrClr),
        .o_RxData       (o_RxData),
        .o_RxValid      (o_RxValid),
        .o_LinkUp       (o_LinkUp),
        .o_FrameErr     (o_FrameErr),
        .o_Stuck        (o_Stuck),
        .o_ErrCnt       (o_ErrCnt)
    );

    always #5 i_clk = ~i_clk;

    // One strobed bit followed by one idle cycle; strobes counted in both cycles.
    task automatic send_bit(input logic b, input logic clr);
        i_RecoveryData = b;
        i_DataEn = 1'b1;
        i_ErrClr = clr;
        @(posedge i_clk); #1;
        i_DataEn = 1'b0;
        i_ErrClr = 1'b0;
        if (o_RxValid) validCnt++;
        if (o_FrameErr) ferrCnt++;
        @(posedge i_clk); #1;
        if (o_RxValid) validCnt++;
        if (o_FrameErr) ferrCnt++;
    endtask

    // par is the hand-computed parity bit actually placed on the line.
    task automatic send_frame(input logic [7:0] sync, input logic [7:0] pay, input logic par, input logic clrLast);
        logic [16:0] f;
        f = {sync, pay, par};
        for (int i = 16; i >= 0; i--) send_bit(f[i], clrLast && (i == 0));
    endtask

    task automatic clear_counts();
        validCnt = 0;
        ferrCnt = 0;
    endtask

    task automatic test_reset();
        i_res_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({o_RxData, o_RxValid, o_LinkUp, o_FrameErr, o_Stuck, o_ErrCnt} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {o_RxData, o_RxValid, o_LinkUp, o_FrameErr, o_Stuck, o_ErrCnt});
        end
        i_res_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_lock();
        clear_counts();
        send_frame(8'hD5, 8'h3C, 1'b0, 1'b0);
        send_frame(8'hD5, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (o_LinkUp !== 1'b0) begin errors++; $display("FAIL lock_early got=%b exp=0", o_LinkUp); end
        send_frame(8'hD5, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (o_LinkUp !== 1'b1) begin errors++; $display("FAIL lock_third got=%b exp=1", o_LinkUp); end
        checks++;
        if (validCnt !== 0) begin errors++; $display("FAIL lock_no_valid got=%0d exp=0", validCnt); end
        send_frame(8'hD5, 8'hA5, 1'b0, 1'b0);
        checks++;
        if (o_RxData !== 8'hA5 || validCnt !== 1) begin
            errors++; $display("FAIL first_payload data=%h valid=%0d exp=a5/1", o_RxData, validCnt);
        end
    endtask

    task automatic test_parity_err();
        clear_counts();
        send_frame(8'hD5, 8'h3C, 1'b1, 1'b0);
        checks++;
        if (ferrCnt !== 1 || o_ErrCnt !== 8'd1 || o_LinkUp !== 1'b1 || validCnt !== 0) begin
            errors++; $display("FAIL parity_err ferr=%0d cnt=%0d link=%b valid=%0d exp=1/1/1/0", ferrCnt, o_ErrCnt, o_LinkUp, validCnt);
        end
        clear_counts();
        send_frame(8'hD5, 8'h5A, 1'b0, 1'b0);
        checks++;
        if (o_RxData !== 8'h5A || validCnt !== 1) begin
            errors++; $display("FAIL after_parity data=%h valid=%0d exp=5a/1", o_RxData, validCnt);
        end
        // Three more bad frames must not unlock if the good frame cleared the bad count.
        clear_counts();
        for (int k = 0; k < 3; k++) send_frame(8'hD4, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (o_LinkUp !== 1'b1 || ferrCnt !== 3 || o_ErrCnt !== 8'd4) begin
            errors++; $display("FAIL bad_cnt_cleared link=%b ferr=%0d cnt=%0d exp=1/3/4", o_LinkUp, ferrCnt, o_ErrCnt);
        end
        send_frame(8'hD5, 8'h0F, 1'b0, 1'b0);
    endtask

    task automatic test_unlock();
        clear_counts();
        for (int k = 0; k < 3; k++) send_frame(8'hD4, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (o_LinkUp !== 1'b1) begin errors++; $display("FAIL unlock_early got=%b exp=1", o_LinkUp); end
        send_frame(8'hD4, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (o_LinkUp !== 1'b0 || ferrCnt !== 4 || o_ErrCnt !== 8'd8 || o_RxData !== 8'h0F) begin
            errors++; $display("FAIL unlock link=%b ferr=%0d cnt=%0d data=%h exp=0/4/8/0f", o_LinkUp, ferrCnt, o_ErrCnt, o_RxData);
        end
        clear_counts();
        for (int k = 0; k < 3; k++) send_frame(8'hD5, 8'h11, 1'b0, 1'b0);
        checks++;
        if (o_LinkUp !== 1'b1 || validCnt !== 0 || ferrCnt !== 0) begin
            errors++; $display("FAIL relock link=%b valid=%0d ferr=%0d exp=1/0/0", o_LinkUp, validCnt, ferrCnt);
        end
    endtask

    task automatic test_stuck();
        clear_counts();
        for (int k = 0; k < 23; k++) send_bit(1'b1, 1'b0);
        checks++;
        if (o_Stuck !== 1'b0 || o_LinkUp !== 1'b1) begin
            errors++; $display("FAIL stuck_23 stuck=%b link=%b exp=0/1", o_Stuck, o_LinkUp);
        end
        send_bit(1'b1, 1'b0);
        checks++;
        if (o_Stuck !== 1'b1 || o_LinkUp !== 1'b0 || ferrCnt !== 1 || o_ErrCnt !== 8'd9) begin
            errors++; $display("FAIL stuck_24 stuck=%b link=%b ferr=%0d cnt=%0d exp=1/0/1/9", o_Stuck, o_LinkUp, ferrCnt, o_ErrCnt);
        end
        send_bit(1'b0, 1'b0);
        checks++;
        if (o_Stuck !== 1'b0) begin errors++; $display("FAIL stuck_clear got=%b exp=0", o_Stuck); end
        for (int k = 0; k < 3; k++) send_frame(8'hD5, 8'h11, 1'b0, 1'b0);
        checks++;
        if (o_LinkUp !== 1'b1) begin errors++; $display("FAIL stuck_relock got=%b exp=1", o_LinkUp); end
    endtask

    task automatic test_errcnt_sat();
        clear_counts();
        for (int g = 0; g < 82; g++) begin
            for (int k = 0; k < 3; k++) send_frame(8'hD5, 8'h66, 1'b1, 1'b0);
            send_frame(8'hD5, 8'h66, 1'b0, 1'b0);
        end
        checks++;
        if (o_ErrCnt !== 8'd255 || ferrCnt !== 246 || validCnt !== 82 || o_LinkUp !== 1'b1) begin
            errors++; $display("FAIL errcnt_fill cnt=%0d ferr=%0d valid=%0d link=%b exp=255/246/82/1", o_ErrCnt, ferrCnt, validCnt, o_LinkUp);
        end
        clear_counts();
        send_frame(8'hD5, 8'h66, 1'b1, 1'b0);
        checks++;
        if (o_ErrCnt !== 8'd255 || ferrCnt !== 1) begin
            errors++; $display("FAIL errcnt_sat cnt=%0d ferr=%0d exp=255/1", o_ErrCnt, ferrCnt);
        end
        clear_counts();
        send_frame(8'hD5, 8'h66, 1'b1, 1'b1);
        checks++;
        if (o_ErrCnt !== 8'd0 || ferrCnt !== 1 || o_LinkUp !== 1'b1) begin
            errors++; $display("FAIL errclr_coincident cnt=%0d ferr=%0d link=%b exp=0/1/1", o_ErrCnt, ferrCnt, o_LinkUp);
        end
        clear_counts();
        send_frame(8'hD5, 8'h81, 1'b0, 1'b0);
        checks++;
        if (o_RxData !== 8'h81 || validCnt !== 1) begin
            errors++; $display("FAIL post_clr_good data=%h valid=%0d exp=81/1", o_RxData, validCnt);
        end
    endtask

    task automatic test_enable();
        i_Enable = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_LinkUp !== 1'b0 || o_RxData !== 8'h81 || o_ErrCnt !== 8'd0 || o_RxValid !== 1'b0) begin
            errors++; $display("FAIL disable link=%b data=%h cnt=%0d valid=%b exp=0/81/0/0", o_LinkUp, o_RxData, o_ErrCnt, o_RxValid);
        end
        i_Enable = 1'b1;
        clear_counts();
        for (int k = 0; k < 3; k++) send_frame(8'hD5, 8'h11, 1'b0, 1'b0);
        send_frame(8'hD5, 8'hC3, 1'b0, 1'b0);
        checks++;
        if (o_LinkUp !== 1'b1 || validCnt !== 1 || o_RxData !== 8'hC3) begin
            errors++; $display("FAIL reenable link=%b valid=%0d data=%h exp=1/1/c3", o_LinkUp, validCnt, o_RxData);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] sync;
        sync = 8'hD5;
        clear_counts();
        for (int i = 7; i >= 0; i--) send_bit(sync[i], 1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
        i_res_n = 1'b0;
        #2;
        checks++;
        if ({o_RxData, o_RxValid, o_LinkUp, o_FrameErr, o_Stuck, o_ErrCnt} !== 20'h0) begin
            errors++; $display("FAIL midframe_reset got=%h exp=0", {o_RxData, o_RxValid, o_LinkUp, o_FrameErr, o_Stuck, o_ErrCnt});
        end
        @(posedge i_clk); #1;
        i_res_n = 1'b1;
        for (int k = 0; k < 2; k++) send_frame(8'hD5, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (o_LinkUp !== 1'b0) begin errors++; $display("FAIL reset_relock_early got=%b exp=0", o_LinkUp); end
        send_frame(8'hD5, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (o_LinkUp !== 1'b1 || validCnt !== 0 || ferrCnt !== 0) begin
            errors++; $display("FAIL reset_relock link=%b valid=%0d ferr=%0d exp=1/0/0", o_LinkUp, validCnt, ferrCnt);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_parity_err();
        test_unlock();
        test_stuck();
        test_errcnt_sat();
        test_enable();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
